// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Provides the loader FSM state encoding and the NOP instruction that the
// read port returns whenever no loaded word is available.
package imem_boot_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    // addi x0, x0, 0
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        LOAD,
        CSUM,
        RUN,
        ERROR
    } boot_state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs four little-endian bytes into one 32-bit word.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        returns the byte counter to 0 (held while not loading)
//   byte_valid   byte_in is accepted this clk
//   byte_in      payload byte
//   word_out     assembled word; valid in the clk word_valid is high
//   word_valid   1-clk pulse on the 4th byte of each word (combinational)
module boot_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned LO_W  = 3 * BYTE_W;

    logic [CNT_W-1:0] byte_cnt;
    logic [LO_W-1:0]  lo_bytes;

    // Bytes 0..2 are held; byte 3 completes the word directly from the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            lo_bytes <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            case (byte_cnt)
                2'd0:    lo_bytes[7:0]   <= byte_in;
                2'd1:    lo_bytes[15:8]  <= byte_in;
                2'd2:    lo_bytes[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word_out   = {byte_in, lo_bytes};

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory with a framed byte-stream loader feeding the core fetch port.
// Holds the core in reset until a frame (SYNC, LEN_LO, LEN_HI, 4*N payload bytes)
// is loaded, then serves instructions at pc.
// Optional feature: define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR
// checksum byte over the payload before the core is released.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   rx_valid/rx_data/rx_ready   byte stream handshake (rx_ready combinational)
//   pc, instr_read              core fetch request (instr_read unused)
//   instr_data                  instruction at pc, combinational
//   core_rst_n                  registered active-low reset to the core
//   load_done                   image loaded, core released
//   load_error                  frame rejected, sticky until rst_n
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    input  logic [31:0]       pc,
    input  logic              instr_read,
    output logic [WORD_W-1:0] instr_data,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned CMP_W = LEN_W + 1;

    boot_state_t       state;
    boot_state_t       state_next;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_full;
    logic [CW-1:0]     word_cnt;
    logic              accept;
    logic              asm_clear;
    logic              asm_valid;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              last_word;
    logic [AW-1:0]     rd_idx;
    logic              rd_in_range;
    logic              rd_loaded;
    logic [WORD_W-1:0] mem [MEM_WORDS];
    logic              unused_ok;

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    assign rx_ready  = state inside {IDLE, LEN0, LEN1, LOAD, CSUM};
    assign accept    = rx_valid && rx_ready;
    assign asm_clear = (state != LOAD);
    assign asm_valid = accept && (state == LOAD);
    assign len_full  = {rx_data, len[7:0]};
    assign last_word = word_valid && ((CMP_W'(word_cnt) + CMP_W'(1)) == CMP_W'(len));
    assign unused_ok = ^{instr_read, pc[1:0]};

    boot_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (rx_data),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) state_next = LEN0;
            end
            LEN0: begin
                if (accept) state_next = LEN1;
            end
            LEN1: begin
                if (accept) begin
                    if (len_full == '0) begin
                        state_next = RUN;
                    end else if (CMP_W'(len_full) > CMP_W'(MEM_WORDS)) begin
                        state_next = ERROR;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (last_word) state_next = CSUM;
`else
                if (last_word) state_next = RUN;
`endif
            end
            CSUM: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (accept) state_next = (rx_data == csum) ? RUN : ERROR;
`endif
            end
            RUN:     state_next = RUN;
            ERROR:   state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    // Length latch, word counter and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len        <= '0;
            word_cnt   <= '0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            if (accept && (state == LEN0)) len[7:0]  <= rx_data;
            if (accept && (state == LEN1)) len[15:8] <= rx_data;
            if ((state == IDLE) && (state_next == LEN0)) begin
                word_cnt <= '0;
            end else if (word_valid) begin
                word_cnt <= word_cnt + CW'(1);
            end
            core_rst_n <= (state == RUN);
            load_done  <= (state == RUN);
            load_error <= load_error || (state_next == ERROR);
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Running XOR over payload bytes, restarted at each frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if ((state == IDLE) && (state_next == LEN0)) begin
            csum <= '0;
        end else if (asm_valid) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    // Memory array is deliberately not reset so contents survive a mid-load reset
    always_ff @(posedge clk) begin
        if (word_valid) mem[word_cnt[AW-1:0]] <= word_out;
    end

    // Words beyond the loaded count (or beyond the array) read as NOP
    assign rd_idx      = pc[AW+1:2];
    assign rd_in_range = (pc[31:AW+2] == '0);
    assign rd_loaded   = (CW'(rd_idx) < word_cnt);
    assign instr_data  = ((state == RUN) && rd_in_range && rd_loaded) ? mem[rd_idx] : NOP_INSTR;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (small memory instance).
module tb_imem_boot_loader;

    localparam int unsigned MEM_WORDS = 16;
    localparam logic [31:0] NOP       = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] pc;
    logic        instr_read;
    logic [31:0] instr_data;
    logic        core_rst_n;
    logic        load_done;
    logic        load_error;

    int n_tests;
    int n_fail;

    imem_boot_loader #(
        .MEM_WORDS (MEM_WORDS),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .pc         (pc),
        .instr_read (instr_read),
        .instr_data (instr_data),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready);
        end
        n_tests++;
        if ({core_rst_n, load_done, load_error} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status got %b exp 000", {core_rst_n, load_done, load_error});
        end
        n_tests++;
        if (instr_data !== NOP) begin
            n_fail++; $display("FAIL reset_instr got %h exp %h", instr_data, NOP);
        end
    endtask

    task automatic test_basic_load();
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_word(32'h00100513);
        send_word(32'h00200593);
        n_tests++;
        if (core_rst_n !== 1'b0 || rx_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_run_entry core_rst_n=%b rx_ready=%b exp 0 0", core_rst_n, rx_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (core_rst_n !== 1'b1 || load_done !== 1'b1) begin
            n_fail++; $display("FAIL basic_release core_rst_n=%b load_done=%b exp 1 1", core_rst_n, load_done);
        end
        pc = 32'd4; #1;
        n_tests++;
        if (instr_data !== 32'h00200593) begin
            n_fail++; $display("FAIL basic_pc4 got %h exp 00200593", instr_data);
        end
        pc = 32'd0; #1;
        n_tests++;
        if (instr_data !== 32'h00100513) begin
            n_fail++; $display("FAIL basic_pc0 got %h exp 00100513", instr_data);
        end
        pc = 32'd5; #1;
        n_tests++;
        if (instr_data !== 32'h00200593) begin
            n_fail++; $display("FAIL basic_misaligned got %h exp 00200593", instr_data);
        end
    endtask

    task automatic test_junk_and_range();
        do_reset();
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDEADBEEF);
        @(posedge clk); #1;
        n_tests++;
        if (load_done !== 1'b1 || load_error !== 1'b0) begin
            n_fail++; $display("FAIL junk_load_done done=%b err=%b exp 1 0", load_done, load_error);
        end
        pc = 32'd0; #1;
        n_tests++;
        if (instr_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL junk_pc0 got %h exp deadbeef", instr_data);
        end
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       pc = 32'd8;
                1:       pc = 32'd60;
                2:       pc = 32'd64;
                default: pc = 32'hFFFF_FFFC;
            endcase
            #1;
            n_tests++;
            if (instr_data !== NOP) begin
                n_fail++; $display("FAIL range_nop pc=%h got %h exp %h", pc, instr_data, NOP);
            end
        end
    endtask

    task automatic test_len_limits();
        logic bad;
        do_reset();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
        n_tests++;
        if (rx_ready !== 1'b1 || load_error !== 1'b0) begin
            n_fail++; $display("FAIL len_max_accept rx_ready=%b err=%b exp 1 0", rx_ready, load_error);
        end
        do_reset();
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h00);
        n_tests++;
        if (load_error !== 1'b1 || rx_ready !== 1'b0) begin
            n_fail++; $display("FAIL len_over err=%b rx_ready=%b exp 1 0", load_error, rx_ready);
        end
        bad = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (core_rst_n !== 1'b0 || load_error !== 1'b1 || rx_ready !== 1'b0 || load_done !== 1'b0) bad = 1'b1;
        end
        rx_valid = 1'b0;
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL len_over_hold core_rst_n=%b err=%b exp 0 1 for 100 clk", core_rst_n, load_error);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        @(posedge clk); #1;
        n_tests++;
        if (load_done !== 1'b1 || core_rst_n !== 1'b1) begin
            n_fail++; $display("FAIL zero_len_run done=%b core_rst_n=%b exp 1 1", load_done, core_rst_n);
        end
        for (int i = 0; i < 4; i++) begin
            pc = 32'(i * 20);
            #1;
            n_tests++;
            if (instr_data !== NOP) begin
                n_fail++; $display("FAIL zero_len_nop pc=%h got %h exp %h", pc, instr_data, NOP);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
        send_word(32'h0BADF00D);
        send_word(32'hCAFE0001);
        n_tests++;
        if (core_rst_n !== 1'b0 || load_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_partial core_rst_n=%b done=%b exp 0 0", core_rst_n, load_done);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (core_rst_n !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_async core_rst_n=%b rx_ready=%b exp 0 1", core_rst_n, rx_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_word(32'h00000093);
        n_tests++;
        if (core_rst_n !== 1'b0 || load_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reload_entry core_rst_n=%b done=%b exp 0 0", core_rst_n, load_done);
        end
        @(posedge clk); #1;
        n_tests++;
        if (load_done !== 1'b1 || core_rst_n !== 1'b1) begin
            n_fail++; $display("FAIL mid_reload_done done=%b core_rst_n=%b exp 1 1", load_done, core_rst_n);
        end
        pc = 32'd0; #1;
        n_tests++;
        if (instr_data !== 32'h00000093) begin
            n_fail++; $display("FAIL mid_new_word got %h exp 00000093", instr_data);
        end
        n_tests++;
        if (dut.mem[1] !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL mid_old_word got %h exp cafe0001", dut.mem[1]);
        end
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        // 13 ^ 05 ^ 10 ^ 00 = 06
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_word(32'h00100513);
        send_byte(8'h06);
        @(posedge clk); #1;
        n_tests++;
        if (load_done !== 1'b1 || load_error !== 1'b0) begin
            n_fail++; $display("FAIL csum_good done=%b err=%b exp 1 0", load_done, load_error);
        end
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_word(32'h00100513);
        send_byte(8'h07);
        @(posedge clk); #1;
        n_tests++;
        if (load_error !== 1'b1 || load_done !== 1'b0 || core_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL csum_bad err=%b done=%b core_rst_n=%b exp 1 0 0", load_error, load_done, core_rst_n);
        end
    endtask
`endif

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        instr_read = 1'b1;
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        pc         = 32'h0;
        test_reset();
        test_basic_load();
        test_junk_and_range();
        test_len_limits();
        test_zero_len();
        test_mid_reset();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
